// File: rtl/gh_uart_tx_seq.sv
// gh_uart_tx_seq: UART transmit sequencer.
//
// Takes characters from the TX FIFO over a valid/ready handshake and frames each one as
// start bit, DATA_BITS data bits (LSB first), an optional parity bit and one or two stop bits.
// Every bit lasts OVERSAMPLE pulses of the baud-rate enable brc_i.
//
// The data bits are not held in this block. They sit in an external parallel-load,
// right-shifting shift register (zero fill from the MSB side). This block loads that register
// on accept and shifts it once per data bit. The current data bit is read back on sr_lsb_i.
//
// Ports:
//   clk_i         system clock
//   rst_ni        asynchronous reset, active low
//   brc_i         baud-rate enable, one-clock pulse, OVERSAMPLE pulses per bit
//   tx_valid_i    FIFO holds a character
//   tx_data_i     character; bits at and above DATA_BITS are ignored
//   tx_ready_o    sequencer idle, character accepted when tx_valid_i is also high
//   parity_en_i   append a parity bit (latched on accept)
//   parity_even_i 1 = even parity, 0 = odd parity (latched on accept)
//   two_stop_i    1 = two stop bits (latched on accept)
//   brk_i         force the serial line low without disturbing sequencing
//   sr_load_o     shift register parallel load strobe
//   sr_se_o       shift register shift enable
//   sr_d_o        shift register load data
//   sr_lsb_i      shift register bit 0
//   sout_o        serial line
//   busy_o        frame in progress
//   tx_done_o     one-clock pulse in the cycle that completes the last stop bit
module gh_uart_tx_seq #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       brc_i,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  input  logic       parity_en_i,
  input  logic       parity_even_i,
  input  logic       two_stop_i,
  input  logic       brk_i,
  output logic       sr_load_o,
  output logic       sr_se_o,
  output logic [7:0] sr_d_o,
  input  logic       sr_lsb_i,
  output logic       sout_o,
  output logic       busy_o,
  output logic       tx_done_o
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop1  = 3'd4;
  localparam logic [2:0] StStop2  = 3'd5;

  localparam logic [3:0] TimerMax = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BitMax   = 3'(DATA_BITS - 1);
  localparam logic [7:0] DataMask = 8'((1 << DATA_BITS) - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] timer_q, timer_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       par_en_q, par_en_d;
  logic       two_stop_q, two_stop_d;
  logic       parity_q, parity_d;

  logic       idle;
  logic       accept;
  logic       bit_end;
  logic [7:0] data_masked;

  assign idle        = (state_q == StIdle);
  assign accept      = tx_valid_i & idle;
  assign data_masked = tx_data_i & DataMask;
  // brc_i is ignored outside a frame, so the timer only ever runs while busy.
  assign bit_end     = ~idle & brc_i & (timer_q == TimerMax);

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bitcnt_d   = bitcnt_q;
    par_en_d   = par_en_q;
    two_stop_d = two_stop_q;
    parity_d   = parity_q;

    if (!idle && brc_i) begin
      timer_d = bit_end ? 4'd0 : timer_q + 4'd1;
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          // Frame configuration is captured here and held until the next accept.
          par_en_d   = parity_en_i;
          two_stop_d = two_stop_i;
          parity_d   = (^data_masked) ^ ~parity_even_i;
          timer_d    = 4'd0;
          bitcnt_d   = 3'd0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bitcnt_q == BitMax) begin
            bitcnt_d = 3'd0;
            state_d  = par_en_q ? StParity : StStop1;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop1;
        end
      end
      StStop1: begin
        if (bit_end) begin
          state_d = two_stop_q ? StStop2 : StIdle;
        end
      end
      StStop2: begin
        if (bit_end) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      timer_q    <= 4'd0;
      bitcnt_q   <= 3'd0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      parity_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bitcnt_q   <= bitcnt_d;
      par_en_q   <= par_en_d;
      two_stop_q <= two_stop_d;
      parity_q   <= parity_d;
    end
  end

  // Handshake and shift register control.
  // sr_load_o only fires in idle and sr_se_o only in data, so they never overlap.
  assign tx_ready_o = idle;
  assign busy_o     = ~idle;
  assign sr_load_o  = accept;
  assign sr_d_o     = accept ? data_masked : 8'd0;
  assign sr_se_o    = (state_q == StData) & bit_end;
  assign tx_done_o  = bit_end & (((state_q == StStop1) & ~two_stop_q) | (state_q == StStop2));

  // Serial line decode. Break overrides the line but never the sequencing.
  always_comb begin
    sout_o = 1'b1;
    case (state_q)
      StIdle:   sout_o = 1'b1;
      StStart:  sout_o = 1'b0;
      StData:   sout_o = sr_lsb_i;
      StParity: sout_o = parity_q;
      StStop1:  sout_o = 1'b1;
      StStop2:  sout_o = 1'b1;
      default:  sout_o = 1'b1;
    endcase
    if (brk_i) begin
      sout_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_gh_uart_tx_seq.sv
`timescale 1ns/1ps
module tb_gh_uart_tx_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       brc = 1'b0;
  int         brc_div = 1;
  int         brc_cnt = 0;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       parity_en, parity_even, two_stop, brk;
  logic       sel;  // 0: observe the 8-bit DUT, 1: observe the 5-bit DUT

  logic       tx_ready8, sr_load8, sr_se8, sout8, busy8, tx_done8;
  logic [7:0] sr_d8, sr8;
  logic       tx_ready5, sr_load5, sr_se5, sout5, busy5, tx_done5;
  logic [7:0] sr_d5, sr5;

  int n_checks = 0;
  int n_fails  = 0;

  // Baud enable: one pulse every brc_div clocks.
  always @(posedge clk) begin
    if (brc_cnt >= brc_div - 1) begin
      brc_cnt <= 0;
      brc     <= 1'b1;
    end else begin
      brc_cnt <= brc_cnt + 1;
      brc     <= 1'b0;
    end
  end

  // External shift registers, reset from the same source as the sequencer.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sr8 <= 8'd0;
    else if (sr_load8) sr8 <= sr_d8;
    else if (sr_se8)   sr8 <= {1'b0, sr8[7:1]};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sr5 <= 8'd0;
    else if (sr_load5) sr5 <= sr_d5;
    else if (sr_se5)   sr5 <= {1'b0, sr5[7:1]};
  end

  gh_uart_tx_seq #(.DATA_BITS(8), .OVERSAMPLE(16)) u_dut8 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .brc_i        (brc),
    .tx_valid_i   (tx_valid & ~sel),
    .tx_data_i    (tx_data),
    .tx_ready_o   (tx_ready8),
    .parity_en_i  (parity_en),
    .parity_even_i(parity_even),
    .two_stop_i   (two_stop),
    .brk_i        (brk),
    .sr_load_o    (sr_load8),
    .sr_se_o      (sr_se8),
    .sr_d_o       (sr_d8),
    .sr_lsb_i     (sr8[0]),
    .sout_o       (sout8),
    .busy_o       (busy8),
    .tx_done_o    (tx_done8)
  );

  gh_uart_tx_seq #(.DATA_BITS(5), .OVERSAMPLE(16)) u_dut5 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .brc_i        (brc),
    .tx_valid_i   (tx_valid & sel),
    .tx_data_i    (tx_data),
    .tx_ready_o   (tx_ready5),
    .parity_en_i  (parity_en),
    .parity_even_i(parity_even),
    .two_stop_i   (two_stop),
    .brk_i        (brk),
    .sr_load_o    (sr_load5),
    .sr_se_o      (sr_se5),
    .sr_d_o       (sr_d5),
    .sr_lsb_i     (sr5[0]),
    .sout_o       (sout5),
    .busy_o       (busy5),
    .tx_done_o    (tx_done5)
  );

  logic       m_ready, m_load, m_se, m_sout, m_busy, m_done;
  logic [7:0] m_sr_d;
  assign m_ready = sel ? tx_ready5 : tx_ready8;
  assign m_load  = sel ? sr_load5  : sr_load8;
  assign m_se    = sel ? sr_se5    : sr_se8;
  assign m_sout  = sel ? sout5     : sout8;
  assign m_busy  = sel ? busy5     : busy8;
  assign m_done  = sel ? tx_done5  : tx_done8;
  assign m_sr_d  = sel ? sr_d5     : sr_d8;

  typedef struct {
    int bits;       // mid-bit line samples, bit i of the frame at position i
    int sr_d;
    int done_brc;   // brc pulses from accept up to and including tx_done
    int done_clks;  // clocks from accept to tx_done, -1 = not checked
    int se_cnt;
    int se_gap;     // clocks between first two shift enables, -1 = not checked
    int gap;        // clocks from previous tx_done to this accept, -1 = not checked
    int high;       // line seen high at any point in the frame
    int aborted;
  } frame_t;

  frame_t exp_q[$];

  task automatic cmp(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int bits, input int sr_d, input int done_brc, input int done_clks,
                      input int se_cnt, input int se_gap, input int gap, input int high,
                      input int aborted);
    frame_t f;
    f.bits = bits; f.sr_d = sr_d; f.done_brc = done_brc; f.done_clks = done_clks;
    f.se_cnt = se_cnt; f.se_gap = se_gap; f.gap = gap; f.high = high; f.aborted = aborted;
    exp_q.push_back(f);
  endtask

  task automatic finish_frame(input frame_t got);
    frame_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL unexpected_frame: got frame with sr_d 0x%0h, expected none", got.sr_d);
      return;
    end
    e = exp_q.pop_front();
    cmp("aborted", got.aborted, e.aborted);
    cmp("sr_d", got.sr_d, e.sr_d);
    if (e.aborted == 0) begin
      cmp("serial_bits", got.bits, e.bits);
      cmp("done_brc", got.done_brc, e.done_brc);
      if (e.done_clks >= 0) cmp("done_clks", got.done_clks, e.done_clks);
      cmp("sr_se_count", got.se_cnt, e.se_cnt);
      if (e.se_gap >= 0) cmp("bit_time_clks", got.se_gap, e.se_gap);
      if (e.gap >= 0) cmp("idle_gap", got.gap, e.gap);
      cmp("line_high_seen", got.high, e.high);
    end
  endtask

  // Monitor: reconstructs each frame from the observed DUT outputs.
  frame_t cur;
  bit     in_frame = 1'b0;
  int     clks, brcs, se_cnt, se1;
  int     gap_cnt  = 1000;
  int     done_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      if (in_frame) begin
        cur.aborted = 1;
        finish_frame(cur);
      end
      in_frame = 1'b0;
      gap_cnt  = 1000;
    end else begin
      if (m_done) done_cnt++;
      if (in_frame) begin
        clks++;
        if (brc) begin
          brcs++;
          if ((brcs - 1) % 16 == 7 && (brcs - 1) / 16 < 12)
            cur.bits = cur.bits | (int'(m_sout) << ((brcs - 1) / 16));
        end
        if (m_sout) cur.high = 1;
        if (m_se) begin
          se_cnt++;
          if (se_cnt == 1) se1 = clks;
          else if (se_cnt == 2) cur.se_gap = clks - se1;
        end
        if (m_done) begin
          cur.done_brc  = brcs;
          cur.done_clks = clks;
          cur.se_cnt    = se_cnt;
          finish_frame(cur);
          in_frame = 1'b0;
          gap_cnt  = 0;
        end
      end else begin
        if (gap_cnt < 1000) gap_cnt++;
        if (m_done) begin
          n_checks++;
          n_fails++;
          $display("FAIL spurious_tx_done: got tx_done 1 while idle, expected 0");
        end
      end
      if (m_load) begin
        in_frame      = 1'b1;
        cur.bits      = 0;
        cur.sr_d      = int'(m_sr_d);
        cur.done_brc  = -1;
        cur.done_clks = -1;
        cur.se_cnt    = 0;
        cur.se_gap    = -1;
        cur.gap       = gap_cnt;
        cur.high      = 0;
        cur.aborted   = 0;
        clks = 0; brcs = 0; se_cnt = 0; se1 = 0;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic pe, input logic pev, input logic ts,
                      input bit keep);
    int t;
    @(negedge clk);
    tx_data = d; parity_en = pe; parity_even = pev; two_stop = ts; tx_valid = 1'b1;
    t = 0;
    while (!m_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!m_ready) begin
      n_checks++;
      n_fails++;
      $display("FAIL accept_timeout: got tx_ready 0, expected 1");
    end
    @(posedge clk);
    #1;
    if (!keep) tx_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    cmp("frames_outstanding", exp_q.size(), 0);
    exp_q.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test, expected completion");
    summary();
    $fatal(1, "time limit reached");
  end

  initial begin
    int d0;
    rst_n = 1'b0; sel = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    parity_en = 1'b0; parity_even = 1'b0; two_stop = 1'b0; brk = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    cmp("rst_sout", int'(sout8), 1);
    cmp("rst_busy", int'(busy8), 0);
    cmp("rst_tx_done", int'(tx_done8), 0);
    cmp("rst_sr_load", int'(sr_load8), 0);
    cmp("rst_sr_se", int'(sr_se8), 0);
    cmp("rst_sr_d", int'(sr_d8), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    cmp("rst_tx_ready", int'(tx_ready8), 1);

    // 8N1 0x55, brc every clock.
    push(12'h2AA, 8'h55, 160, 160, 8, 16, -1, 1, 0);
    send(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // 8E1 0xA3; config toggled mid-frame must not matter.
    push(12'h546, 8'hA3, 176, 176, 8, 16, -1, 1, 0);
    send(8'hA3, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    parity_en = 1'b0; parity_even = 1'b0; two_stop = 1'b1;
    drain();

    // 8O1 0xA3.
    push(12'h746, 8'hA3, 176, 176, 8, 16, -1, 1, 0);
    send(8'hA3, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    // 8N2 back-to-back 0x00 then 0xFF with tx_valid held.
    push(12'h600, 8'h00, 176, 176, 8, 16, -1, 1, 0);
    push(12'h7FE, 8'hFF, 176, 176, 8, 16, 1, 1, 0);
    send(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    send(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();

    // Break across a whole 0xFF frame: line stays low, timing unchanged.
    brk = 1'b1;
    push(12'h000, 8'hFF, 160, 160, 8, 16, -1, 0, 0);
    send(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    brk = 1'b0;

    // Reset in the middle of the data bits.
    push(0, 8'hFF, 0, 0, 0, 0, 0, 0, 1);
    send(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (60) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    cmp("midrst_sout", int'(sout8), 1);
    cmp("midrst_busy", int'(busy8), 0);
    cmp("midrst_sr_se", int'(sr_se8), 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    cmp("midrst_tx_ready", int'(tx_ready8), 1);
    cmp("midrst_busy_rel", int'(busy8), 0);
    cmp("midrst_sout_rel", int'(sout8), 1);
    repeat (200) @(negedge clk);
    cmp("midrst_no_tx_done", done_cnt, d0);
    drain();

    // brc every third clock: idle pulses do nothing, then a 48-clock bit time.
    brc_div = 3;
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      repeat (10) @(negedge clk);
      cmp("idle_brc_busy", int'(busy8), 0);
      cmp("idle_brc_sout", int'(sout8), 1);
    end
    cmp("idle_brc_no_done", done_cnt, d0);
    push(12'h2AA, 8'h55, 160, -1, 8, 48, -1, 1, 0);
    send(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // DATA_BITS = 5, 0xFF, even parity.
    brc_div = 1;
    @(negedge clk);
    sel = 1'b1;
    push(12'h0FE, 8'h1F, 128, 128, 5, 16, -1, 1, 0);
    send(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();

    summary();
    $finish;
  end

endmodule

// File: doc/gh_uart_tx_seq.md
# gh_uart_tx_seq

UART transmit sequencer that drives an external parallel-load, right-shifting shift register (load/shift-enable, zero fill toward LSB) to serialise one character per frame. It accepts bytes from a FIFO via valid/ready, frames them with start, optional parity and 1 or 2 stop bits, and paces every bit from a 16x baud-rate enable. It sits between the TX FIFO and the serial output pin of the UART core.

## Interface
- DATA_BITS, 8, character length, legal 5..8
- OVERSAMPLE, 16, brc pulses per bit time, legal 2..16
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low (asserted at 0)
- brc  in  1  baud-rate enable, one-clk pulse, OVERSAMPLE per bit
- tx_valid  in  1  FIFO has a character
- tx_data  in  8  character, LSB transmitted first; bits above DATA_BITS ignored
- tx_ready  out  1  accept strobe qualifier
- parity_en  in  1  append parity bit
- parity_even  in  1  1 = even parity, 0 = odd
- two_stop  in  1  1 = two stop bits
- brk  in  1  force line low (break)
- sr_load  out  1  shift register parallel load
- sr_se  out  1  shift register shift enable
- sr_d  out  8  shift register load data
- sr_lsb  in  1  shift register q[0]
- sout  out  1  serial line
- busy  out  1  frame in progress
- tx_done  out  1  one-clk pulse at frame end

## Operation
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- Reset values: state IDLE, sout 1, tx_ready 1 after reset release, busy 0, tx_done 0, sr_load 0, sr_se 0, sr_d 0, all counters 0.
- tx_ready = (state == IDLE). Accept = tx_valid & tx_ready.
- On accept: sr_load = 1 for that cycle, sr_d = tx_data with bits [7:DATA_BITS] forced 0; latch parity_en, parity_even, two_stop; compute parity = XOR(masked data) for even, its inverse for odd; clear bit timer and bit counter; next state START.
- Bit timer: 4-bit counter increments on each brc; when it reaches OVERSAMPLE-1 and brc is high, the bit ends (timer returns to 0). brc outside a frame ignored.
- START -> DATA at bit end.
- DATA: sout = sr_lsb. At each bit end assert sr_se for exactly that cycle, increment bit counter; after bit DATA_BITS-1 go to PARITY if parity_en latched, else STOP1.
- PARITY -> STOP1 at bit end; STOP1 -> STOP2 if two_stop latched, else IDLE; STOP2 -> IDLE.
- tx_done pulses on the edge entering IDLE from a stop state.
- sout decode (combinational from registered state/inputs): IDLE 1, START 0, DATA sr_lsb, PARITY latched parity, STOP1/STOP2 1; brk = 1 forces sout 0 in all states without altering sequencing.
- busy = (state != IDLE).
- sr_load and sr_se never asserted in the same cycle.
- Config inputs changing mid-frame have no effect until next accept.
- Reset mid-frame: immediate return to reset values; partial frame abandoned; the integrator resets the shift register from the same reset source.

## Timing
- Accept edge: START entered, sout falls the next cycle; shift register holds data one clk later.
- Frame length = OVERSAMPLE x (1 + DATA_BITS + parity_en + 1 + two_stop) brc pulses from accept.
- Back-to-back: tx_ready high in the cycle after tx_done; with tx_valid held, next accept occurs there, giving exactly one idle clk (sout 1) between frames.
- sr_se asserted in the same cycle as the brc that ends each data bit; sr_lsb shows the next bit on the following clk.
- tx_ready low for the whole frame; tx_valid ignored while busy.

## Test plan
- 8N1, brc every clk, tx_data 0x55 -> sout 0 then 1,0,1,0,1,0,1,0 then 1, each 16 clks; tx_done at clk 160 after accept; 8 sr_se pulses.
- 8E1, tx_data 0xA3 -> data bits 1,1,0,0,0,1,0,1, parity 0, stop 1; odd parity with same data -> parity 1; frame 176 brc.
- 8N2, two chars 0x00 then 0xFF with tx_valid held -> 16+128+32 clks per frame, single idle clk between, tx_done twice.
- DATA_BITS=5, tx_data 0xFF, even parity -> five 1 data bits, parity 1, sr_d = 0x1F.
- brk=1 during DATA of 0xFF -> sout 0 throughout, tx_done still at nominal time; rst=0 asserted mid-DATA -> sout 1, busy 0, tx_ready 1 on release, no tx_done.
- brc every 3rd clk -> bit time 48 clks; brc pulses during IDLE cause no state change.
